aes_ct_collector: RTL and testbench
===================================

// Module: aes_ct_collector
// PURPOSE
//   Downstream stage of aes_8_bit: gathers its byte-serial ciphertext (d_out/d_vld)
//   into 128-bit blocks and buffers them for a 128-bit valid/ready consumer.
//   First byte received is the block MSB [127:120], matching the byte order of the
//   core's key/data loading. A small FIFO absorbs consumer back-pressure.
// PARAMETERS
//   BLOCK_BYTES  16  bytes per block; ct_out width = 8*BLOCK_BYTES
//   FIFO_DEPTH   2   completed blocks buffered (power of 2, >=2)
//   TIMEOUT_CYC  32  idle cycles allowed between bytes of one block (AES_CT_TIMEOUT_EN only)
// PORTS
//   clk        in   1    clock, all logic rising-edge
//   rst        in   1    synchronous, active-high reset
//   d_in       in   8    ciphertext byte from aes_8_bit d_out
//   d_vld      in   1    d_in valid; one byte accepted per cycle it is high (no back-pressure)
//   ct_out     out  128  head-of-FIFO ciphertext block
//   ct_valid   out  1    FIFO not empty
//   ct_ready   in   1    consumer accepts ct_out when ct_valid & ct_ready
//   byte_cnt   out  4    bytes collected into the current partial block (0..15)
//   overflow   out  1    sticky: a completed block was dropped (FIFO full)
//   frag_err   out  1    sticky: partial block discarded by timeout
// BEHAVIOUR
//   Reset (rst=1 at clk edge): byte_cnt=0, FIFO empty, ct_valid=0, ct_out=0,
//     overflow=0, frag_err=0; partial block discarded. Reset mid-block or with full
//     FIFO discards everything; no output beat is produced after reset until 16 new bytes.
//   Assembly: on d_vld, shift register {sr[119:0], d_in}; byte_cnt increments.
//     Gaps (d_vld=0) between bytes allowed; no state change in gap cycles.
//   Completion: the 16th accepted byte wraps byte_cnt 15->0 and pushes {sr[119:0],d_in}
//     into the FIFO that same edge; ct_valid rises the next cycle (latency 1 cycle
//     from the 16th byte's edge to ct_valid high). Back-to-back blocks sustained.
//   Output: ct_out/ct_valid stable while ct_valid & !ct_ready. Pop on ct_valid & ct_ready.
//   FIFO full + push, no pop: new block dropped, overflow<=1, FIFO contents unchanged.
//   FIFO full + push + pop same cycle: both occur, no drop, occupancy stays full.
//   FIFO empty: ct_out holds last popped value (0 after reset); do not depend on it.
//   States (collector): IDLE (byte_cnt=0) -> COLLECT on first byte -> IDLE on 16th byte.
//   Sticky flags clear only on rst.
// CONFIGURATION
//   AES_CT_TIMEOUT_EN defined: in COLLECT an idle counter counts consecutive d_vld=0
//     cycles; reaching TIMEOUT_CYC discards the partial block (byte_cnt<=0, ->IDLE),
//     sets frag_err. Counter clears on every accepted byte; a byte arriving in the
//     timeout cycle is taken as byte 0 of a new block. Not counted in IDLE.
//   Undefined: no timeout logic; partial blocks wait indefinitely; frag_err tied 0.
// TESTING
//   1 Key 000102..0f / PT 00112233..ff through aes_8_bit, 16 bytes contiguous ->
//     ct_out=69c4e0d86a7b0430d8cdb78070b4c55a, ct_valid high 1 cycle after 16th byte.
//   2 Bytes 00..0f with 1-3 cycle gaps, ct_ready=1 -> ct_out=000102030405060708090a0b0c0d0e0f,
//     ct_valid exactly one cycle, byte_cnt 0..15 then 0.
//   3 ct_ready=0, feed 3 blocks (A,B,C) -> A,B held, C dropped, overflow=1; then
//     ct_ready=1 -> A then B popped, ct_valid falls.
//   4 FIFO full, 16th byte of C coincides with pop of A -> no drop, overflow=0, order B,C.
//   5 rst asserted after 7 bytes and with 1 block queued -> ct_valid=0, byte_cnt=0;
//     next 16 bytes yield one correct block.
//   6 (AES_CT_TIMEOUT_EN) 5 bytes, 32 idle cycles -> frag_err=1, byte_cnt=0; next 16
//     bytes form a correct block; with macro off, same stimulus completes after 11 more bytes.

Source files
------------

// File: rtl/aes_ct_collector_if.sv
// Ciphertext collector bus: byte-serial input from the AES core and the
// 128-bit valid/ready block output toward the consumer.
interface aes_ct_collector_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [7:0]               d_in;
    logic                     d_vld;
    logic [8*BLOCK_BYTES-1:0] ct_out;
    logic                     ct_valid;
    logic                     ct_ready;

    modport master (
        output d_in, d_vld, ct_ready,
        input  ct_out, ct_valid
    );

    modport slave (
        input  d_in, d_vld, ct_ready,
        output ct_out, ct_valid
    );
endinterface

// File: rtl/aes_ct_collector.sv
// Packs aes_8_bit ciphertext bytes (first byte = MSB) into blocks and queues them.
// Define AES_CT_TIMEOUT_EN to discard stalled partial blocks and flag frag_err.
module aes_ct_collector #(
    parameter int BLOCK_BYTES = 16,
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    aes_ct_collector_if.slave              bus,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_cnt,
    output logic                           overflow,
    output logic                           frag_err
);
    localparam int W  = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]   state;
    logic [W-9:0] sr;
    logic [W-9:0] sr_shift;
    logic [W-1:0] blk;
    logic         tmo;
    logic         push;
    logic         pop;
    logic         full;
    logic         do_push;

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [W-1:0]  last_q;

    assign sr_shift = {sr[W-17:0], bus.d_in};
    assign blk      = {sr, bus.d_in};
    assign push     = (state == COLLECT) && bus.d_vld && !tmo
                      && (byte_cnt == LAST);

`ifdef AES_CT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_cnt;

    assign tmo = (state == COLLECT) && (idle_cnt == IW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst || bus.d_vld || tmo || state == IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) frag_err <= 1'b0;
        else if (tmo) frag_err <= 1'b1;
    end
`else
    assign tmo      = 1'b0;
    assign frag_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            sr       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.d_vld) begin
                        sr       <= sr_shift;
                        byte_cnt <= CW'(1);
                        state    <= COLLECT;
                    end
                end
                default: begin
                    if (tmo) begin
                        // A byte landing in the timeout cycle starts a fresh block
                        if (bus.d_vld) begin
                            sr       <= sr_shift;
                            byte_cnt <= CW'(1);
                        end else begin
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end
                    end else if (bus.d_vld) begin
                        sr <= sr_shift;
                        if (byte_cnt == LAST) begin
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = bus.ct_valid && bus.ct_ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= blk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (push && full && !pop) overflow <= 1'b1;
            if (do_push && !pop) count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
        end
    end

    // Empty FIFO shows the last popped block rather than a stale slot
    assign bus.ct_valid = (count != '0);
    assign bus.ct_out   = bus.ct_valid ? mem[rd_ptr] : last_q;
endmodule

// File: tb/tb_aes_ct_collector.sv
// Directed bench for aes_ct_collector: assembly, latency, back-pressure,
// overflow, simultaneous push/pop, reset and the fragment timeout.
module tb_aes_ct_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] byte_cnt;
    logic       overflow;
    logic       frag_err;

    int vectors = 0;
    int errs    = 0;

    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] BA     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BB     = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] BC     = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
    localparam logic [127:0] BD     = 128'h11111111222222223333333344444444;
    localparam logic [127:0] BE     = 128'hdeadbeefcafef00d0badc0de12345678;
    localparam logic [127:0] BF     = 128'h0123456789abcdeffedcba9876543210;

    aes_ct_collector_if #(.BLOCK_BYTES(16)) bus ();

    aes_ct_collector dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .byte_cnt (byte_cnt),
        .overflow (overflow),
        .frag_err (frag_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.d_in  = b;
        bus.d_vld = 1'b1;
        tick();
        bus.d_vld = 1'b0;
    endtask

    task automatic feed(input logic [127:0] v, input int first, input int last);
        logic [127:0] t;
        t = v;
        for (int i = first; i <= last; i++) send(t[127-8*i -: 8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] t;
        rst          = 1'b1;
        bus.d_in     = 8'h00;
        bus.d_vld    = 1'b0;
        bus.ct_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_byte_cnt", 128'(byte_cnt), 128'd0);
        chk("rst_ct_valid", 128'(bus.ct_valid), 128'd0);
        chk("rst_ct_out", bus.ct_out, 128'd0);
        chk("rst_overflow", 128'(overflow), 128'd0);
        chk("rst_frag_err", 128'(frag_err), 128'd0);

        // AES FIPS-197 ciphertext, contiguous bytes
        feed(AES_CT, 0, 14);
        chk("t1_valid_before", 128'(bus.ct_valid), 128'd0);
        chk("t1_cnt15", 128'(byte_cnt), 128'd15);
        feed(AES_CT, 15, 15);
        chk("t1_valid", 128'(bus.ct_valid), 128'd1);
        chk("t1_ct_out", bus.ct_out, AES_CT);
        chk("t1_cnt_wrap", 128'(byte_cnt), 128'd0);
        tick();
        chk("t1_hold_valid", 128'(bus.ct_valid), 128'd1);
        chk("t1_hold_out", bus.ct_out, AES_CT);
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
        chk("t1_popped", 128'(bus.ct_valid), 128'd0);
        chk("t1_last_out", bus.ct_out, AES_CT);

        // Gapped bytes with ready held high
        bus.ct_ready = 1'b1;
        t = SEQ;
        for (int i = 0; i < 16; i++) begin
            chk("t2_valid_low", 128'(bus.ct_valid), 128'd0);
            send(t[127-8*i -: 8]);
            chk("t2_cnt", 128'(byte_cnt), 128'((i + 1) % 16));
            if (i < 15) repeat ((i % 3) + 1) tick();
        end
        chk("t2_valid", 128'(bus.ct_valid), 128'd1);
        chk("t2_ct_out", bus.ct_out, SEQ);
        tick();
        chk("t2_one_cycle", 128'(bus.ct_valid), 128'd0);
        bus.ct_ready = 1'b0;

        // Back-pressure: third block dropped
        feed(BA, 0, 15);
        feed(BB, 0, 15);
        chk("t3_no_ovf_yet", 128'(overflow), 128'd0);
        feed(BC, 0, 15);
        chk("t3_overflow", 128'(overflow), 128'd1);
        chk("t3_head_a", bus.ct_out, BA);
        bus.ct_ready = 1'b1;
        tick();
        chk("t3_head_b", bus.ct_out, BB);
        chk("t3_valid_b", 128'(bus.ct_valid), 128'd1);
        tick();
        bus.ct_ready = 1'b0;
        chk("t3_drained", 128'(bus.ct_valid), 128'd0);
        chk("t3_ovf_sticky", 128'(overflow), 128'd1);

        // Full FIFO: completion coincides with a pop
        do_reset();
        chk("t4_ovf_cleared", 128'(overflow), 128'd0);
        feed(BA, 0, 15);
        feed(BB, 0, 15);
        feed(BC, 0, 14);
        t = BC;
        bus.d_in     = t[7:0];
        bus.d_vld    = 1'b1;
        bus.ct_ready = 1'b1;
        tick();
        bus.d_vld    = 1'b0;
        bus.ct_ready = 1'b0;
        chk("t4_no_ovf", 128'(overflow), 128'd0);
        chk("t4_head_b", bus.ct_out, BB);
        bus.ct_ready = 1'b1;
        tick();
        chk("t4_head_c", bus.ct_out, BC);
        chk("t4_valid_c", 128'(bus.ct_valid), 128'd1);
        tick();
        bus.ct_ready = 1'b0;
        chk("t4_drained", 128'(bus.ct_valid), 128'd0);

        // Reset mid-block with a queued block
        feed(BA, 0, 15);
        feed(BD, 0, 6);
        chk("t5_cnt7", 128'(byte_cnt), 128'd7);
        chk("t5_queued", 128'(bus.ct_valid), 128'd1);
        do_reset();
        chk("t5_rst_valid", 128'(bus.ct_valid), 128'd0);
        chk("t5_rst_cnt", 128'(byte_cnt), 128'd0);
        chk("t5_rst_out", bus.ct_out, 128'd0);
        feed(BE, 0, 14);
        chk("t5_no_early", 128'(bus.ct_valid), 128'd0);
        feed(BE, 15, 15);
        chk("t5_valid", 128'(bus.ct_valid), 128'd1);
        chk("t5_ct_out", bus.ct_out, BE);
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
        chk("t5_drained", 128'(bus.ct_valid), 128'd0);

        // Stalled partial block
        feed(BF, 0, 4);
        repeat (33) tick();
`ifdef AES_CT_TIMEOUT_EN
        chk("t6_frag_err", 128'(frag_err), 128'd1);
        chk("t6_cnt_zero", 128'(byte_cnt), 128'd0);
        feed(BE, 0, 15);
        chk("t6_valid", 128'(bus.ct_valid), 128'd1);
        chk("t6_ct_out", bus.ct_out, BE);
`else
        chk("t6_frag_err", 128'(frag_err), 128'd0);
        chk("t6_cnt_kept", 128'(byte_cnt), 128'd5);
        feed(BF, 5, 14);
        chk("t6_no_early", 128'(bus.ct_valid), 128'd0);
        feed(BF, 15, 15);
        chk("t6_valid", 128'(bus.ct_valid), 128'd1);
        chk("t6_ct_out", bus.ct_out, BF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
